// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver: captures words on rx_done_tick,
// exposes the head word combinationally, and reports occupancy plus sticky overflow.
module uart_rx_fifo #(
  parameter int DBIT     = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_done_tick,
  input  logic [DBIT-1:0]          rx_dout,
  input  logic                     rd_en,
  output logic [DBIT-1:0]          rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);
  localparam int ADDR = $clog2(DEPTH);
  localparam logic [ADDR:0] AF_THR = (ADDR+1)'(AF_LEVEL);

  logic [ADDR:0]   wr_ptr, rd_ptr;
  logic [DBIT-1:0] mem [DEPTH];
  logic            push, pop, ovf_evt;

  // Status derives purely from the registered pointers, so it follows reset at once.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]) && (wr_ptr[ADDR] != rd_ptr[ADDR]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AF_THR);
  assign rd_data     = empty ? '0 : mem[rd_ptr[ADDR-1:0]];

  assign pop     = rd_en && !empty;
  assign push    = rx_done_tick && (!full || pop);
  assign ovf_evt = rx_done_tick && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A new drop outranks a simultaneous clear.
      if (ovf_evt)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR-1:0]] <= rx_dout;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected words, a negedge
// monitor checks every accepted pop against the queue head.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done_tick, rd_en, ovf_clr;
  logic [7:0] rx_dout, rd_data;
  logic       empty, full, almost_full, overflow;
  logic [4:0] count;

  int         vecs = 0, errs = 0;
  int         mcnt = 0;
  bit         movf = 1'b0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DBIT(8), .DEPTH(16), .AF_LEVEL(12)) dut (
    .clk(clk), .rst(rst), .rx_done_tick(rx_done_tick), .rx_dout(rx_dout),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flags();
    chk("count", int'(count), mcnt);
    chk("empty", int'(empty), int'(mcnt == 0));
    chk("full", int'(full), int'(mcnt == 16));
    chk("almost_full", int'(almost_full), int'(mcnt >= 12));
    chk("overflow", int'(overflow), int'(movf));
    if (mcnt == 0) chk("rd_data_empty", int'(rd_data), 0);
  endtask

  // One clock of stimulus; expected acceptance is modelled from the bench's own count.
  task automatic cyc(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    bit p, w;
    rx_done_tick = wr; rx_dout = d; rd_en = rd; ovf_clr = clr;
    p = rd && (mcnt != 0);
    w = wr && ((mcnt != 16) || p);
    if (w) sb.push_back(d);
    if (wr && (mcnt == 16) && !p) movf = 1'b1;
    else if (clr)                 movf = 1'b0;
    mcnt = mcnt + int'(w) - int'(p);
    @(posedge clk); #1;
    rx_done_tick = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; rx_dout = '0;
    flags();
  endtask

  // Monitor: the head word must match the scoreboard whenever a pop is accepted.
  always @(negedge clk) begin
    if (!rst && rd_en && !empty) begin
      if (sb.size() == 0) begin
        vecs++; errs++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no data", rd_data);
      end else begin
        chk("pop_data", int'(rd_data), int'(sb.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; rx_done_tick = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; rx_dout = '0;
    #3;
    flags();
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word round trip
    cyc(1, 8'hA5, 0, 0);
    chk("rd_data_a5", int'(rd_data), 8'hA5);
    cyc(0, 8'h00, 1, 0);

    // Fill to full, then drain in order
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);

    // Overflow set, clear, and set-beats-clear
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    cyc(1, 8'hFF, 0, 0);
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'hFF, 0, 1);
    cyc(0, 8'h00, 0, 1);

    // Simultaneous push and pop while full
    cyc(1, 8'h55, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    chk("sb_drained", sb.size(), 0);

    // Interleaved traffic across pointer wrap
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'(i * 7 + 3), bit'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 2)) cyc(0, 8'h00, bit'($urandom_range(0, 1)), 0);
    end
    while (mcnt > 0) cyc(0, 8'h00, 1, 0);
    chk("sb_drained2", sb.size(), 0);

    // Asynchronous reset mid-stream
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    #2 rst = 1'b1;
    sb.delete(); mcnt = 0; movf = 1'b0;
    #1;
    flags();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 8'h3C, 0, 0);
    chk("rd_data_3c", int'(rd_data), 8'h3C);
    cyc(0, 8'h00, 1, 0);
    chk("sb_final", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
